// File: rtl/online_checker_r4_pkg.sv
// ---------------------------------------------------------------------------
// online_r4_pkg
// Shared definitions for the radix-4 online-adder result checker.
//   DIGIT_W        bits per signed result digit (two's complement)
//   DIGIT_MIN/MAX  legal digit range {-3..3}
//   DIGIT_ILLEGAL  the one code a 3-bit digit can carry outside that range (-4)
//   state_e        checker FSM states
//   acc_width()    signed accumulator width for an (n+1)-digit radix-4 value
//   is_illegal()   flags a digit code outside the legal set
// ---------------------------------------------------------------------------
package online_r4_pkg;

    localparam int DIGIT_W = 3;

    localparam logic signed [DIGIT_W-1:0] DIGIT_MIN     = 3'sb101;  // -3
    localparam logic signed [DIGIT_W-1:0] DIGIT_MAX     = 3'sb011;  // +3
    localparam logic        [DIGIT_W-1:0] DIGIT_ILLEGAL = 3'b100;   // -4

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_e;

    // |value| <= 3 * (4^(n+1)-1)/3 = 4^(n+1)-1 needs 2*(n+1) magnitude bits plus sign.
    function automatic int acc_width(input int n);
        return 2 * (n + 1) + 1;
    endfunction

    // -4 is the only out-of-range code for 3-bit digits; the range test keeps
    // the intent explicit should the digit set ever be narrowed.
    function automatic logic is_illegal(input logic signed [DIGIT_W-1:0] d);
        return (d == DIGIT_ILLEGAL) || (d < DIGIT_MIN) || (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/online_checker_r4_digit_acc.sv
// ---------------------------------------------------------------------------
// r4_digit_acc
// Radix-4 MSD-first value accumulator: acc <= 4*acc + sext(digit).
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset, clears the accumulator
//   clear_i   start of a new number (takes priority over en_i)
//   en_i      accumulate digit_i this cycle
//   digit_i   C-bit two's complement digit
//   acc_d_o   accumulator value after this cycle's update (next-state view),
//             so the caller can judge a full number on the cycle its last
//             digit arrives
// ---------------------------------------------------------------------------
module r4_digit_acc
    import online_r4_pkg::*;
#(
    parameter int C     = DIGIT_W,
    parameter int ACC_W = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [C-1:0]            digit_i,
    output logic signed [ACC_W-1:0] acc_d_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] digit_ext;

    always_comb begin
        digit_ext = {{(ACC_W-C){digit_i[C-1]}}, digit_i};
        acc_d     = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            // Shift by one radix-4 position, then add the new digit. Wraps
            // silently only when an illegal -4 digit pushes past the range.
            acc_d = {acc_q[ACC_W-3:0], 2'b00} + digit_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_d_o = acc_d;

endmodule

// File: rtl/online_checker_r4.sv
// ---------------------------------------------------------------------------
// online_checker_r4
// Receive end of the radix-4 online-adder test path. Collects N+1 MSD-first
// signed digits from the adder and compares them against the expected
// packed vector latched at start. Reports digit-exact match, numeric value
// match (the adder may legally produce a different redundant encoding of the
// same number) and a timeout if the stream stalls.
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   start          pulse: latch z_exp and arm a check (ignored while busy)
//   z_exp          expected digits, MSD in the top C bits
//   d_valid        d_in carries a digit this cycle (consumed only while busy)
//   d_in           received digit, MSD first
//   busy           high exactly while collecting
//   done           one-cycle pulse; results valid from here until next start
//   digit_match    all digits identical to z_exp
//   value_match    numeric values equal (no timeout, no illegal digit)
//   timeout        stream stalled for TIMEOUT cycles
//   illegal_digit  a -4 code was received
//   err_count      number of mismatching digit positions
//   first_err_idx  first mismatching position, 0 = MSD (0 if none)
//   z_got          received digits, packed like z_exp (shifted in from LSB)
// ---------------------------------------------------------------------------
module online_checker_r4
    import online_r4_pkg::*;
#(
    parameter int N       = 6,
    parameter int C       = DIGIT_W,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [(N+1)*C-1:0]       z_exp,
    input  logic                     d_valid,
    input  logic [C-1:0]             d_in,
    output logic                     busy,
    output logic                     done,
    output logic                     digit_match,
    output logic                     value_match,
    output logic                     timeout,
    output logic                     illegal_digit,
    output logic [$clog2(N+2)-1:0]   err_count,
    output logic [$clog2(N+1)-1:0]   first_err_idx,
    output logic [(N+1)*C-1:0]       z_got
);

    localparam int W      = (N + 1) * C;
    localparam int ACC_W  = acc_width(N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int ERR_W  = $clog2(N + 2);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // ---------------- state and result registers ----------------
    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [W-1:0]        z_exp_q;
    logic [W-1:0]        z_got_q;
    logic [ERR_W-1:0]    err_q;
    logic [CNT_W-1:0]    first_q;
    logic                illegal_q;
    logic                busy_q;
    logic                done_q;
    logic                dmatch_q;
    logic                vmatch_q;
    logic                timeout_q;

    // ---------------- per-cycle decode ----------------
    logic                accept;
    logic                arm;
    logic                digit_bad;
    logic                mismatch;
    logic [C-1:0]        exp_digit;
    logic [ERR_W-1:0]    err_d;
    logic                illegal_d;
    logic signed [ACC_W-1:0] acc_got_d;
    logic signed [ACC_W-1:0] acc_exp_d;

    // Unpack the latched expected vector so position 0 is the MSD.
    logic [C-1:0] exp_digits [N+1];

    for (genvar gi = 0; gi <= N; gi++) begin : g_exp_unpack
        assign exp_digits[gi] = z_exp_q[(N-gi)*C +: C];
    end

    always_comb begin
        accept    = (state_q == COLLECT) && d_valid;
        // A new check can be armed from IDLE or from the REPORT cycle.
        arm       = start && ((state_q == IDLE) || (state_q == REPORT));
        exp_digit = exp_digits[cnt_q];
        digit_bad = is_illegal(d_in);
        // An illegal digit counts as a mismatch even if z_exp held the same code.
        mismatch  = accept && ((d_in != exp_digit) || digit_bad);
        err_d     = err_q + ERR_W'(mismatch);
        illegal_d = illegal_q | (accept & digit_bad);
    end

    // ---------------- value accumulators ----------------
    r4_digit_acc #(
        .C     (C),
        .ACC_W (ACC_W)
    ) u_acc_got (
        .clk     (clk),
        .reset   (reset),
        .clear_i (arm),
        .en_i    (accept),
        .digit_i (d_in),
        .acc_d_o (acc_got_d)
    );

    r4_digit_acc #(
        .C     (C),
        .ACC_W (ACC_W)
    ) u_acc_exp (
        .clk     (clk),
        .reset   (reset),
        .clear_i (arm),
        .en_i    (accept),
        .digit_i (exp_digit),
        .acc_d_o (acc_exp_d)
    );

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idle_q    <= '0;
            z_exp_q   <= '0;
            z_got_q   <= '0;
            err_q     <= '0;
            first_q   <= '0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dmatch_q  <= 1'b0;
            vmatch_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (d_valid) begin
                        z_got_q   <= {z_got_q[W-C-1:0], d_in};
                        err_q     <= err_d;
                        illegal_q <= illegal_d;
                        if (mismatch && (err_q == '0)) begin
                            first_q <= cnt_q;
                        end
                        idle_q <= '0;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(N)) begin
                            // Verdict uses the next-state views so the final
                            // digit is included without an extra cycle.
                            state_q  <= REPORT;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            dmatch_q <= (err_d == '0);
                            vmatch_q <= (acc_got_d == acc_exp_d) && !illegal_d;
                        end
                    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th consecutive idle cycle.
                        state_q   <= REPORT;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        dmatch_q  <= 1'b0;
                        vmatch_q  <= 1'b0;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end

                REPORT: begin
                    if (start) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Accepted start: results of the previous check are dropped here,
            // not earlier, so they hold through IDLE.
            if (arm) begin
                z_exp_q   <= z_exp;
                cnt_q     <= '0;
                idle_q    <= '0;
                z_got_q   <= '0;
                err_q     <= '0;
                first_q   <= '0;
                illegal_q <= 1'b0;
                dmatch_q  <= 1'b0;
                vmatch_q  <= 1'b0;
                timeout_q <= 1'b0;
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign digit_match   = dmatch_q;
    assign value_match   = vmatch_q;
    assign timeout       = timeout_q;
    assign illegal_digit = illegal_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign z_got         = z_got_q;

endmodule
